// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Drain stage between a FIFO read port and a valid/ready stream consumer.
//   Issues fifo_rd_en whenever the FIFO has data and the local skid buffer
//   can absorb the word, then hides the FIFO's one-cycle read latency in a
//   3-entry buffer.
//   Each word is presented as a stream beat. m_last marks every PKT_LEN-th beat.
//
// Parameters
//   FIFO_WIDTH  word width (must match the FIFO data width)
//   PKT_LEN     beats per packet (>= 1)
//
// Ports
//   clk             single clock, rising edge
//   rst             synchronous active-high reset
//   fifo_empty      FIFO empty flag (combinational in the FIFO)
//   fifo_underflow  FIFO underflow flag, registered, aligned with read data
//   fifo_data_out   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en      read request to the FIFO
//   m_valid/m_ready stream handshake
//   m_data          stream beat data
//   m_last          final beat of a packet
//   err_underflow   sticky underflow flag      (FIFO_RD_STREAM_ERR_EN only)
//   err_cnt         saturating underflow count (FIFO_RD_STREAM_ERR_EN only)
//
// Build option
//   FIFO_RD_STREAM_ERR_EN  adds err_underflow / err_cnt. Without it, an
//   underflowed read is simply not captured.

module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef FIFO_RD_STREAM_ERR_EN
  ,
  output logic                  err_underflow,
  output logic [7:0]            err_cnt
`endif
);

  localparam int BCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(PKT_LEN - 1);

  logic [1:0]            occ;
  logic [1:0]            wr_idx;
  logic [1:0]            rd_idx;
  logic                  pending;
  logic [BCW-1:0]        beat_cnt;
  logic [FIFO_WIDTH-1:0] skid_mem [3];
  logic [2:0]            inflight;
  logic                  capture;
  logic                  pop;

  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Counting the in-flight read as occupied space keeps occ + pending <= 3,
  // so the buffer cannot overflow. The request is built from registered
  // state only, with no path from m_ready.
  assign inflight   = {1'b0, occ} + {2'b00, pending};
  assign fifo_rd_en = !rst && !fifo_empty && (inflight < 3'd3);

  assign capture = pending && !fifo_underflow;
  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = skid_mem[rd_idx];
  assign m_last  = m_valid && (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      pending  <= 1'b0;
      wr_idx   <= 2'd0;
      rd_idx   <= 2'd0;
      beat_cnt <= '0;
    end else begin
      pending <= fifo_rd_en;
      if (capture) wr_idx <= idx_inc(wr_idx);
      if (pop)     rd_idx <= idx_inc(rd_idx);
      case ({capture, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (pop) beat_cnt <= m_last ? '0 : beat_cnt + BCW'(1);
    end
  end

  // Data storage needs no reset; entries are only read while occ says valid.
  always_ff @(posedge clk) begin
    if (!rst && capture) skid_mem[wr_idx] <= fifo_data_out;
  end

`ifdef FIFO_RD_STREAM_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
      err_cnt       <= 8'd0;
    end else if (pending && fifo_underflow) begin
      err_underflow <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a small behavioural FIFO in front.
// Words queued in to_push enter the FIFO one per clock. A word equal to
// uf_tag is returned as an underflowed read, with the flag aligned to the data.

module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic [15:0] fifo_data_out;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
`ifdef FIFO_RD_STREAM_ERR_EN
  logic        err_underflow;
  logic [7:0]  err_cnt;
`endif

  fifo_rd_stream #(.FIFO_WIDTH(16), .PKT_LEN(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last)
`ifdef FIFO_RD_STREAM_ERR_EN
    ,
    .err_underflow  (err_underflow),
    .err_cnt        (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  logic        fifo_clr;
  logic [15:0] uf_tag;
  logic [15:0] to_push [$];
  logic [15:0] fmem [0:63];
  logic [5:0]  fhead;
  logic [5:0]  ftail;
  int          fcount = 0;

  assign fifo_empty = (fcount == 0);

  always @(posedge clk) begin
    if (fifo_clr) begin
      fhead          <= '0;
      ftail          <= '0;
      fcount         <= 0;
      fifo_underflow <= 1'b0;
      to_push.delete();
    end else begin
      fcount <= fcount + ((to_push.size() > 0) ? 1 : 0)
                       - ((fifo_rd_en && fcount > 0) ? 1 : 0);
      fifo_underflow <= 1'b0;
      if (fifo_rd_en && fcount > 0) begin
        if (fmem[fhead] == uf_tag) begin
          fifo_data_out  <= 16'hDEAD;
          fifo_underflow <= 1'b1;
        end else begin
          fifo_data_out <= fmem[fhead];
        end
        fhead <= fhead + 6'd1;
      end else if (fifo_rd_en) begin
        fifo_underflow <= 1'b1;
      end
      if (to_push.size() > 0) begin
        fmem[ftail] <= to_push.pop_front();
        ftail       <= ftail + 6'd1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] pop_data [$];
  logic        pop_last [$];
  int          rd_seen;

  // Called just after a rising edge. Samples each cycle mid-cycle, then
  // advances one clock.
  task automatic run(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      #1;
      if (fifo_rd_en) rd_seen++;
      if (m_valid && m_ready) begin
        pop_data.push_back(m_data);
        pop_last.push_back(m_last);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_pops();
    pop_data.delete();
    pop_last.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    fifo_clr = 1'b1;
    m_ready  = 1'b0;
    uf_tag   = 16'hFFFF;
    rd_seen  = 0;
    @(posedge clk); #1;

    // ---- reset held while the FIFO fills ----
    fifo_clr = 1'b0;
    for (int w = 1; w <= 8; w++) to_push.push_back(16'(w));
    for (int c = 0; c < 10; c++) begin
      #1;
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_valid", m_valid, 0);
      @(posedge clk); #1;
    end
`ifdef FIFO_RD_STREAM_ERR_EN
    check("rst_err_flag", err_underflow, 0);
    check("rst_err_cnt", err_cnt, 0);
`endif

    // ---- release and stream 8 words at full rate ----
    rst     = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      #1;
      check("strm_rd_en", fifo_rd_en, (c < 8));
      check("strm_valid", m_valid, (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) begin
        check("strm_data", m_data, c - 1);
        check("strm_last", m_last, ((c - 1) % 4 == 0));
      end
      @(posedge clk); #1;
    end

    // ---- backpressure ----
    m_ready = 1'b0;
    rd_seen = 0;
    clear_pops();
    for (int w = 1; w <= 8; w++) to_push.push_back(16'(w));
    run(14);
    check("bp_reads", rd_seen, 3);
    #1;
    check("bp_valid", m_valid, 1);
    check("bp_hold_data", m_data, 16'h0001);
    check("bp_hold_last", m_last, 0);
    run(3);
    check("bp_reads_still", rd_seen, 3);
    check("bp_hold_data2", m_data, 16'h0001);
    m_ready = 1'b1;
    run(20);
    check("bp_total_reads", rd_seen, 8);
    check("bp_beats", pop_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("bp_data", pop_data[i], i + 1);
      check("bp_last", pop_last[i], (i == 3 || i == 7));
    end

    // ---- single word at the empty boundary ----
    rd_seen = 0;
    clear_pops();
    to_push.push_back(16'h00AA);
    run(8);
    check("eb_reads", rd_seen, 1);
    check("eb_beats", pop_data.size(), 1);
    check("eb_data", pop_data[0], 16'h00AA);
    check("eb_last", pop_last[0], 0);
    check("eb_beat_cnt", dut.beat_cnt, 1);
    to_push.push_back(16'h00BB);
    run(8);
    check("eb_reads2", rd_seen, 2);
    check("eb_beats2", pop_data.size(), 2);
    check("eb_data2", pop_data[1], 16'h00BB);
    check("eb_last2", pop_last[1], 0);

    // ---- underflowed read is not captured ----
    rd_seen = 0;
    clear_pops();
    uf_tag = 16'h00DD;
    to_push.push_back(16'h00CC);
    to_push.push_back(16'h00DD);
    to_push.push_back(16'h00EE);
    run(10);
    check("uf_reads", rd_seen, 3);
    check("uf_beats", pop_data.size(), 2);
    check("uf_data0", pop_data[0], 16'h00CC);
    check("uf_last0", pop_last[0], 0);
    check("uf_data1", pop_data[1], 16'h00EE);
    check("uf_last1", pop_last[1], 1);
`ifdef FIFO_RD_STREAM_ERR_EN
    check("uf_err_flag", err_underflow, 1);
    check("uf_err_cnt", err_cnt, 1);
`endif
    clear_pops();
    uf_tag = 16'h0011;
    to_push.push_back(16'h0011);
    to_push.push_back(16'h0022);
    run(8);
    check("uf2_beats", pop_data.size(), 1);
    check("uf2_data", pop_data[0], 16'h0022);
    check("uf2_last", pop_last[0], 0);
`ifdef FIFO_RD_STREAM_ERR_EN
    check("uf2_err_flag", err_underflow, 1);
    check("uf2_err_cnt", err_cnt, 2);
`endif
    uf_tag = 16'hFFFF;

    // ---- reset in the middle of a packet ----
    m_ready = 1'b0;
    clear_pops();
    for (int w = 0; w < 6; w++) to_push.push_back(16'h0031 + 16'(w));
    run(12);
    m_ready = 1'b1;
    run(2);
    check("mr_beats", pop_data.size(), 2);
    check("mr_data0", pop_data[0], 16'h0031);
    check("mr_data1", pop_data[1], 16'h0032);
    check("mr_pre_cnt", dut.beat_cnt, 3);
    rst      = 1'b1;
    fifo_clr = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    fifo_clr = 1'b0;
    #1;
    check("mr_valid", m_valid, 0);
    check("mr_beat_cnt", dut.beat_cnt, 0);
    check("mr_rd_en", fifo_rd_en, 0);
`ifdef FIFO_RD_STREAM_ERR_EN
    check("mr_err_flag", err_underflow, 0);
    check("mr_err_cnt", err_cnt, 0);
`endif
    @(posedge clk); #1;
    rd_seen = 0;
    clear_pops();
    for (int w = 0; w < 4; w++) to_push.push_back(16'h0041 + 16'(w));
    run(12);
    check("mr_reads", rd_seen, 4);
    check("mr_refill_beats", pop_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("mr_refill_data", pop_data[i], 16'h0041 + i);
      check("mr_refill_last", pop_last[i], (i == 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Downstream drain stage for the FIFO: issues `fifo_rd_en` whenever the FIFO holds data and local space exists, and absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer. It presents the words as a valid/ready stream, with `m_last` marking every PKT_LEN-th beat. It sits between the FIFO read port and any stream consumer (packetizer, serializer), and gives full one-word-per-cycle throughput without a combinational path from `m_ready` to `fifo_rd_en`.

## Interface
- FIFO_WIDTH, 16, word width; must match the FIFO data width.
- PKT_LEN, 4, number of beats per packet; must be ≥1.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag (combinational from the FIFO count).
- fifo_underflow  in  1  FIFO underflow flag (registered, valid the cycle after a refused read).
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after `fifo_rd_en`.
- fifo_rd_en  out  1  read request to the FIFO.
- m_valid  out  1  output beat valid.
- m_ready  in  1  consumer accepts the beat.
- m_data  out  FIFO_WIDTH  output beat data.
- m_last  out  1  final beat of the packet.
- err_underflow  out  1  sticky error flag; present only with FIFO_RD_STREAM_ERR_EN.
- err_cnt  out  8  error count, saturating; present only with FIFO_RD_STREAM_ERR_EN.

## Operation
- State:
  - `occ`: 0..3, number of buffer entries.
  - `pending`: 1 bit, a read was issued last cycle.
  - `wr_idx`, `rd_idx`: 2 bits each, wrap 2→0.
  - `beat_cnt`: $clog2(PKT_LEN) bits, minimum 1.
- Read issue:
  - `fifo_rd_en = !rst && !fifo_empty && (occ + pending) < 3`.
  - The term depends only on registered state and `fifo_empty`.
- Pending tracking: `pending <= fifo_rd_en` each cycle.
- Capture:
  - When `pending && !fifo_underflow`, write `fifo_data_out` to `buf[wr_idx]` and advance `wr_idx`.
  - When `pending && fifo_underflow`, capture nothing.
- Pop:
  - `pop = m_valid && m_ready`; advance `rd_idx` on pop.
  - Capture and pop in the same cycle leave `occ` unchanged.
- Output:
  - `m_valid = (occ != 0)`; `m_data = buf[rd_idx]`.
  - While `m_valid && !m_ready`, `m_data` and `m_last` stay stable.
- Packet framing:
  - `m_last = m_valid && beat_cnt == PKT_LEN-1`.
  - On pop, `beat_cnt` increments, or wraps to 0 when the popped beat had `m_last`.
  - With PKT_LEN=1, `m_last` equals `m_valid`.
- Buffer overflow is structurally impossible: occ + pending ≤ 3 always.
- Reset values: `occ=0`, `pending=0`, `wr_idx=0`, `rd_idx=0`, `beat_cnt=0`, `m_valid=0`, `m_last=0`, `fifo_rd_en=0` (combinationally gated by `rst`), `err_underflow=0`, `err_cnt=0`; `m_data` is don't-care while `m_valid=0`.
- Reset mid-operation:
  - A read in flight and all buffered words are discarded.
  - The FIFO is reset in the same cycle at top level (`rst_n = ~rst`).

## Timing
- Read latency: `fifo_rd_en` high in cycle t → `fifo_data_out` valid in t+1 → captured at edge t+2 → `m_valid` high from cycle t+2.
- Throughput: with `m_ready=1`, steady state is `occ=1`, `pending=1`, one read and one beat per cycle.
- Backpressure: with `m_ready=0`, at most 3 reads issue before `fifo_rd_en` drops; it reasserts the cycle after the first pop.
- FIFO boundary: `fifo_empty` reflects the post-read count the cycle after a read, so reading the last word is never followed by a spurious read.
- No combinational path exists from `m_ready` to `fifo_rd_en`.

## Configuration
- Macro: FIFO_RD_STREAM_ERR_EN.
- Defined:
  - `err_underflow` and `err_cnt` ports exist.
  - In a cycle with `pending && fifo_underflow`, `err_underflow` sets sticky (cleared only by `rst`) and `err_cnt` increments, saturating at 255.
- Undefined:
  - Ports and logic are absent.
  - Capture is still gated by `fifo_underflow`; the error is silently dropped.

## Test plan
- Reset: `rst=1` for 3 cycles with `fifo_empty=0` → `fifo_rd_en=0` and `m_valid=0` throughout; `fifo_rd_en=1` in the first cycle after release; `m_valid=1` two cycles later.
- Streaming: FIFO preloaded with 0x0001..0x0008, `m_ready=1` → `fifo_rd_en` high 8 consecutive cycles; `m_data` = 0x0001..0x0008 on consecutive cycles starting 2 cycles after the first read; `m_last` on 0x0004 and 0x0008.
- Backpressure: same preload, `m_ready=0` for 10 cycles → exactly 3 reads; `m_data` holds 0x0001; after `m_ready=1`, the remaining words arrive in order with none lost or duplicated.
- Empty boundary: FIFO holds one word 0x00AA → one `fifo_rd_en`, then `m_valid` for one accepted beat with `m_last=0`; a later write of 0x00BB yields the next beat with `beat_cnt=1`.
- Underflow (macro defined): force `fifo_underflow=1` in a pending cycle → no capture, `occ` unchanged, `err_underflow=1`, `err_cnt=1`; a second injection gives `err_cnt=2`.
- Reset mid-packet: assert `rst` after 2 beats accepted → `m_valid=0` the next cycle and `beat_cnt=0`; after refilling, `m_last` occurs on the 4th accepted beat.
